// File: rtl/float_to_fixed_conv_pkg.sv
// float_fix_pkg: shared types and constants for the float-to-fixed converter.
//   state_t  : converter FSM states (IDLE .. DONE)
//   fclass_t : input classification produced while unpacking
//   IEEE-754 single field widths and exponent bias
//   params_legal(): elaboration-time legality check for W_FIX / FRAC
package float_fix_pkg;

  localparam int EXP_BIAS = 127;
  localparam int MANT_W   = 23;
  localparam int EXP_W    = 8;
  localparam int SIG_W    = 24;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNPACK = 3'd1,
    ALIGN  = 3'd2,
    ROUND  = 3'd3,
    SAT    = 3'd4,
    DONE   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    ZERO   = 2'd0,
    FINITE = 2'd1,
    INF    = 2'd2,
    NAN    = 2'd3
  } fclass_t;

  function automatic bit params_legal(input int w_fix, input int frac);
    return (w_fix >= 8) && (w_fix <= 64) && (frac >= 0) && (frac < w_fix);
  endfunction

endpackage

// File: rtl/float_to_fixed_conv_round_sat.sv
// fix_round_sat: combinational rounding and saturation for the converter.
// Two independent paths, each feeding the next pipeline register:
//   round path : aligned magnitude + guard/round/sticky -> rounded magnitude
//     mode        0 = truncate toward zero, 1 = round-nearest-even
//     amag/abig   aligned magnitude, abig = bits at or above W_FIX were set
//     guard/rnd/sticky  bits shifted out below the result LSB
//     rmag/rbig   rounded magnitude (one extra bit for the carry)
//   sat path   : rounded magnitude + sign + class -> final result and flags
//     sign, cls   captured sign bit and fclass_t code
//     smag/sbig   registered rounded magnitude
//     result      signed fixed-point result
//     ovf/unf/nan_flag  status flags
module fix_round_sat
  import float_fix_pkg::*;
#(
  parameter int W_FIX = 32
) (
  input  logic             mode,
  input  logic [W_FIX-1:0] amag,
  input  logic             abig,
  input  logic             guard,
  input  logic             rnd,
  input  logic             sticky,
  output logic [W_FIX:0]   rmag,
  output logic             rbig,
  input  logic             sign,
  input  logic [1:0]       cls,
  input  logic [W_FIX:0]   smag,
  input  logic             sbig,
  output logic [W_FIX-1:0] result,
  output logic             ovf,
  output logic             unf,
  output logic             nan_flag
);

  localparam logic [W_FIX-1:0] POS_MAX = {1'b0, {(W_FIX-1){1'b1}}};
  localparam logic [W_FIX-1:0] NEG_MIN = {1'b1, {(W_FIX-1){1'b0}}};
  // 2^(W_FIX-1): the largest magnitude a negative result can carry
  localparam logic [W_FIX:0]   NEG_LIM = {2'b01, {(W_FIX-1){1'b0}}};

  logic inc;

  // Round-nearest-even: increment above half, or on an exact half with odd LSB.
  assign inc  = mode & guard & (rnd | sticky | amag[0]);
  assign rmag = {1'b0, amag} + {{W_FIX{1'b0}}, inc};
  assign rbig = abig;

  always_comb begin
    result   = '0;
    ovf      = 1'b0;
    unf      = 1'b0;
    nan_flag = 1'b0;
    case (fclass_t'(cls))
      NAN: nan_flag = 1'b1;
      INF: begin
        ovf    = 1'b1;
        result = sign ? NEG_MIN : POS_MAX;
      end
      FINITE: begin
        if (!sign) begin
          if (sbig || smag[W_FIX] || smag[W_FIX-1]) begin
            ovf    = 1'b1;
            result = POS_MAX;
          end else begin
            result = smag[W_FIX-1:0];
          end
        end else begin
          if (sbig || (smag > NEG_LIM)) begin
            ovf    = 1'b1;
            result = NEG_MIN;
          end else begin
            // smag == 2^(W_FIX-1) negates to NEG_MIN, which is representable
            result = '0 - smag[W_FIX-1:0];
          end
        end
        unf = !ovf && (result == '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/float_to_fixed_conv.sv
// float_to_fixed_conv: IEEE-754 single to signed fixed point (value * 2^FRAC).
// Fixed six-state sequence IDLE->UNPACK->ALIGN->ROUND->SAT->DONE.
// Handshake: Begin_FSM_FF is sampled only in IDLE; F and MODE are captured on
// that edge. BUSY is high from acceptance through the ACK cycle. ACK_FF pulses
// for one cycle (DONE); RESULT and flags change only then and hold until the
// next ACK. Requests outside IDLE are dropped, not queued.
// Ports:
//   CLK, RST_N      clock, synchronous active-low reset
//   Begin_FSM_FF    start request
//   F, MODE         float input, 0 = truncate / 1 = round-nearest-even
//   ACK_FF, BUSY    handshake outputs
//   RESULT          signed W_FIX-bit result
//   OVF, UNF, NAN_FLAG  status flags
//   state_dbg       current FSM state code
module float_to_fixed_conv
  import float_fix_pkg::*;
#(
  parameter int W_FIX = 32,
  parameter int FRAC  = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             Begin_FSM_FF,
  input  logic [31:0]      F,
  input  logic             MODE,
  output logic             ACK_FF,
  output logic             BUSY,
  output logic [W_FIX-1:0] RESULT,
  output logic             OVF,
  output logic             UNF,
  output logic             NAN_FLAG,
  output logic [2:0]       state_dbg
);

  if (!params_legal(W_FIX, FRAC)) begin : g_bad_params
    $error("float_to_fixed_conv: W_FIX must be 8..64 and FRAC 0..W_FIX-1");
  end

  localparam int XW     = W_FIX + SIG_W;  // lossless alignment width
  localparam int EXT_LO = SIG_W + 2;      // guard + round + sticky field width
  // sh = e_eff - (bias + mantissa width) + FRAC
  localparam logic signed [9:0] SH_OFS = 10'(EXP_BIAS + MANT_W - FRAC);

  state_t state;

  logic [31:0]         f_q;
  logic                mode_q;
  logic                sign_q;
  fclass_t             cls_q;
  logic [SIG_W-1:0]    sig_q;
  logic signed [9:0]   sh_q;
  logic [W_FIX-1:0]    amag_q;
  logic                abig_q, g_q, r_q, s_q;
  logic [W_FIX:0]      rmag_q;
  logic                rbig_q;

  assign state_dbg = state;

  // ---------------- unpack ----------------
  logic [EXP_W-1:0]  f_exp;
  logic [MANT_W-1:0] f_man;
  logic signed [9:0] e_eff, sh_c;
  logic [SIG_W-1:0]  sig_c;
  fclass_t           cls_c;

  assign f_exp = f_q[30:23];
  assign f_man = f_q[22:0];
  // Subnormals have no hidden 1 and behave as exponent 1.
  assign sig_c = {(f_exp != '0), f_man};
  assign e_eff = (f_exp == '0) ? 10'sd1 : $signed({2'b00, f_exp});
  assign sh_c  = e_eff - SH_OFS;

  always_comb begin
    if (f_exp == '1)                        cls_c = (f_man != '0) ? NAN : INF;
    else if ((f_exp == '0) && (f_man == '0)) cls_c = ZERO;
    else                                    cls_c = FINITE;
  end

  // ---------------- align ----------------
  logic [XW-1:0]            ext_c;
  logic [SIG_W+EXT_LO-1:0]  rs_wide;
  logic [9:0]               rs_n;
  logic [W_FIX-1:0]         amag_c;
  logic                     abig_c, g_c, r_c, s_c;

  always_comb begin
    ext_c   = '0;
    rs_wide = '0;
    rs_n    = '0;
    abig_c  = 1'b0;
    g_c     = 1'b0;
    r_c     = 1'b0;
    s_c     = 1'b0;
    if (!sh_q[9]) begin
      // Any left shift of W_FIX or more necessarily lands bits out of range.
      if (sh_q >= $signed(10'(W_FIX))) abig_c = 1'b1;
      else                             ext_c  = XW'(sig_q) << sh_q[6:0];
    end else begin
      rs_n = -sh_q;
      if (rs_n >= 10'(EXT_LO)) begin
        s_c = |sig_q;
      end else begin
        rs_wide = {sig_q, {EXT_LO{1'b0}}} >> rs_n[4:0];
        ext_c   = XW'(rs_wide[SIG_W+EXT_LO-1:EXT_LO]);
        g_c     = rs_wide[EXT_LO-1];
        r_c     = rs_wide[EXT_LO-2];
        s_c     = |rs_wide[EXT_LO-3:0];
      end
    end
    // Bit W_FIX-1 stays in the magnitude so -2^(W_FIX-1) can still be produced.
    abig_c = abig_c | (|ext_c[XW-1:W_FIX]);
    amag_c = ext_c[W_FIX-1:0];
  end

  // ---------------- round / saturate ----------------
  logic [W_FIX:0]   rmag_c;
  logic             rbig_c;
  logic [W_FIX-1:0] result_c;
  logic             ovf_c, unf_c, nan_c;

  fix_round_sat #(.W_FIX(W_FIX)) u_round_sat (
    .mode     (mode_q),
    .amag     (amag_q),
    .abig     (abig_q),
    .guard    (g_q),
    .rnd      (r_q),
    .sticky   (s_q),
    .rmag     (rmag_c),
    .rbig     (rbig_c),
    .sign     (sign_q),
    .cls      (cls_q),
    .smag     (rmag_q),
    .sbig     (rbig_q),
    .result   (result_c),
    .ovf      (ovf_c),
    .unf      (unf_c),
    .nan_flag (nan_c)
  );

  // ---------------- FSM and registers ----------------
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= IDLE;
      ACK_FF   <= 1'b0;
      BUSY     <= 1'b0;
      RESULT   <= '0;
      OVF      <= 1'b0;
      UNF      <= 1'b0;
      NAN_FLAG <= 1'b0;
      f_q      <= '0;
      mode_q   <= 1'b0;
      sign_q   <= 1'b0;
      cls_q    <= ZERO;
      sig_q    <= '0;
      sh_q     <= '0;
      amag_q   <= '0;
      abig_q   <= 1'b0;
      g_q      <= 1'b0;
      r_q      <= 1'b0;
      s_q      <= 1'b0;
      rmag_q   <= '0;
      rbig_q   <= 1'b0;
    end else begin
      ACK_FF <= 1'b0;
      case (state)
        IDLE: begin
          if (Begin_FSM_FF) begin
            f_q    <= F;
            mode_q <= MODE;
            BUSY   <= 1'b1;
            state  <= UNPACK;
          end
        end
        UNPACK: begin
          sign_q <= f_q[31];
          cls_q  <= cls_c;
          sig_q  <= sig_c;
          sh_q   <= sh_c;
          state  <= ALIGN;
        end
        ALIGN: begin
          amag_q <= amag_c;
          abig_q <= abig_c;
          g_q    <= g_c;
          r_q    <= r_c;
          s_q    <= s_c;
          state  <= ROUND;
        end
        ROUND: begin
          rmag_q <= rmag_c;
          rbig_q <= rbig_c;
          state  <= SAT;
        end
        SAT: begin
          RESULT   <= result_c;
          OVF      <= ovf_c;
          UNF      <= unf_c;
          NAN_FLAG <= nan_c;
          ACK_FF   <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
